// File: rtl/alu_pkg.sv
// Shared ALU constants and the FSM state type used by the sequential
// subtractor and its slice.
package alu_pkg;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = $clog2(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fullsub_16.sv
// Combinational 16-bit ripple-borrow subtract slice: {bout, diff} = a - b - bin.
module fullsub_16
  import alu_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] diff,
  output logic             bout
);

  always_comb begin
    logic br;
    br   = bin;
    diff = '0;
    for (int k = 0; k < SLICE; k++) begin
      diff[k] = a[k] ^ b[k] ^ br;
      br      = (~a[k] & b[k]) | (~a[k] & br) | (b[k] & br);
    end
    bout = br;
  end

endmodule

// File: rtl/sub64_seq.sv
// Sequential WIDTH-bit subtractor: one SLICE-bit slice per clock with the
// borrow held in a register, valid/ready on both sides.
module sub64_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never drops and data never changes until that edge.
  // WIDTH must equal SLICE*NS; the slice datapath is fixed at 16 bits.
  localparam int NS = WIDTH / SLICE;
  localparam int IW = $clog2(NS);

  state_e state_q, state_d;

  logic [IW-1:0]          idx_q;
  logic                   borrow_q;
  logic [NS-1:0][SLICE-1:0] a_q, b_q, diff_q;
  logic                   bout_q, ovf_q, zero_q;

  logic [SLICE-1:0]         sd;
  logic                     sbo;
  logic [NS-1:0][SLICE-1:0] diff_nx;
  logic                     last_slice;
  logic                     ovf_nx;

  fullsub_16 u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .bin  (borrow_q),
    .diff (sd),
    .bout (sbo)
  );

  assign last_slice = (idx_q == IW'(NS - 1));

  // Full result as it will look after this cycle's slice is written.
  always_comb begin
    diff_nx        = diff_q;
    diff_nx[idx_q] = sd;
  end

  assign ovf_nx = (a_q[NS-1][SLICE-1] ^ b_q[NS-1][SLICE-1]) &
                  (a_q[NS-1][SLICE-1] ^ diff_nx[NS-1][SLICE-1]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            idx_q    <= '0;
          end
        end
        RUN: begin
          diff_q   <= diff_nx;
          borrow_q <= sbo;
          if (last_slice) begin
            bout_q <= sbo;
            ovf_q  <= ovf_nx;
            zero_q <= (diff_nx == '0);
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sub64_seq.sv
// Self-checking bench for sub64_seq: vector table, hand-written hold and
// reset sequences, random back-to-back ops, results checked through a queue.
module tb_sub64_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout, ovf, zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [66:0] exp_q[$];
  logic [66:0] mon_exp;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[8];

  sub64_seq #(.WIDTH(64), .SLICE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [66:0] model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin);
    logic [64:0] r;
    logic        mov;
    r   = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
    mov = (ma[63] ^ mb[63]) & (ma[63] ^ r[63]);
    return {r[63:0], r[64], mov, (r[63:0] == 64'd0)};
  endfunction

  task automatic scramble();
    a   = {$urandom(), $urandom()};
    b   = {$urandom(), $urandom()};
    bin = 1'($urandom_range(0, 1));
  endtask

  // driver: issue one op, push its expectation, verify 4-cycle latency
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tbin,
                        input logic [66:0] exp, output time t_acc);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
    scramble();
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; scramble(); cyc++;
    end
    check("latency", 67'(cyc), 67'(4));
  endtask

  // scoreboard: pop on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_output: got diff %h expected no result", diff);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {diff, bout, ovf, zero}, mon_exp);
      end
    end
  end

  initial begin
    time t_acc, t_prev;
    logic [63:0] ra, rb;
    logic        rbin;
    int          spurious;
    int          wait_cyc;

    vecs[0] = '{64'h0000_0000_0001_0000, 64'h1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{64'h1234, 64'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{64'h5, 64'h3, 1'b1, 64'h1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{64'h0001_0000_0000_0000, 64'h1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {in_ready, out_valid, diff, bout, ovf}, {1'b1, 1'b0, 64'd0, 1'b0, 1'b0});
    check("reset_zero", 67'(zero), 67'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven vectors
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin,
             {vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].z}, t_acc);

    // hold the result with out_ready low; DONE ignores new operands
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 1'b0, {64'd0, 1'b0, 1'b0, 1'b1}, t_acc);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_handshake", {out_valid, in_ready}, {1'b1, 1'b0});
      check("hold_data", {diff, bout, ovf, zero}, {64'd0, 1'b0, 1'b0, 1'b1});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("ready_after_handshake", {in_ready, out_valid}, {1'b1, 1'b0});

    // reset asserted in the second RUN cycle
    a = 64'h1111_2222_3333_4444; b = 64'h0101_0101_0101_0101; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {in_ready, out_valid, diff, bout, ovf}, {1'b1, 1'b0, 64'd0, 1'b0, 1'b0});
    check("midrun_reset_zero", 67'(zero), 67'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    check("no_spurious_valid", 67'(spurious), 67'(0));
    run_op(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b1,
           model(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b1), t_acc);

    // random back-to-back ops: one accept every 6 cycles
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      ra   = {$urandom(), $urandom()};
      rb   = ($urandom_range(0, 3) == 0) ? ra : {$urandom(), $urandom()};
      rbin = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbin, model(ra, rb, rbin), t_acc);
      if (i > 0) check("issue_interval", 67'(t_acc - t_prev), 67'(60));
      t_prev = t_acc;
    end

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk); #1; wait_cyc++;
    end
    check("queue_drained", 67'(exp_q.size()), 67'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
